instruction_fetch_queue: RTL and testbench
==========================================

// Module: instruction_fetch_queue
// PURPOSE
//  Fetch stage that sits directly upstream of the single-cycle core's decode/execute path.
//  Owns the fetch PC and issues word reads to a 1-cycle-latency program memory.
//  Buffers returned instructions, each tagged with its PC, in a small FIFO and hands them downstream over a valid/ready handshake.
//  A redirect (branch/jump) flushes all queued and in-flight instructions and restarts fetch at the new PC.
// PARAMETERS
//  DEPTH       4             FIFO entries; legal range 2..16; full rate needs DEPTH>=3
//  RESET_PC    32'h0040_0000 fetch PC loaded on reset
//  ADDR_WIDTH  32            width of PC and memory address
// PORTS
//  clk            in   1   single clock, all state on rising edge
//  reset          in   1   synchronous, active-high
//  enable_i       in   1   fetch permitted; low = issue no new requests
//  redirect_i     in   1   flush and restart fetch at redirect_pc_i
//  redirect_pc_i  in   32  new fetch PC; bits [1:0] ignored (forced 0)
//  mem_req_o      out  1   read request this cycle
//  mem_addr_o     out  32  word address of request (= fetch PC)
//  mem_rvalid_i   in   1   read data valid; asserted exactly 1 cycle after mem_req_o
//  mem_rdata_i    in   32  instruction word
//  instr_valid_o  out  1   FIFO head valid (count != 0)
//  instr_o        out  32  FIFO head instruction
//  instr_pc_o     out  32  PC of FIFO head instruction
//  instr_ready_i  in   1   consumer accepts head when valid & ready
//  count_o        out  clog2(DEPTH+1)  current FIFO occupancy
// BEHAVIOUR
//  Reset: pc=RESET_PC, count=0, inflight=0, state=S_IDLE.
//   All outputs 0 except mem_addr_o=RESET_PC.
//  FSM:
//   S_IDLE -> S_FETCH when enable_i=1.
//   S_FETCH -> S_IDLE when enable_i=0.
//   An in-flight response is still accepted in S_IDLE.
//  Issue rule: mem_req_o = S_FETCH & enable_i & ~redirect_i & (count+inflight < DEPTH).
//   A pop in the same cycle does not create credit; the FIFO can never overflow.
//  On issue: pc <= pc+4 (mod 2^32, wraps silently); inflight <= 1.
//   With no issue, inflight <= 0. inflight is at most 1 because latency is fixed at 1.
//  Response: mem_rvalid_i & ~redirect_i writes {mem_rdata_i, PC of that request} at the tail, registered.
//   The entry is visible on instr_valid_o the next cycle.
//  Pop: instr_valid_o & instr_ready_i advances the head.
//   Simultaneous push and pop at any count is legal; count is unchanged.
//  Head outputs (instr_o, instr_pc_o) hold stable while valid & ~ready.
//  Redirect (priority over everything else in that cycle):
//   count <= 0; pc <= {redirect_pc_i[31:2],2'b00}; no request issued.
//   A response arriving in the redirect cycle is dropped.
//   Timing: redirect at cycle t -> request at t+1 -> data at t+2 -> instr_valid_o at t+3 (given enable).
//  Redirect while in S_IDLE: updates the PC and flushes only; fetch resumes on enable.
//  Reset mid-operation: discards all entries; any response on the next cycle is ignored (inflight=0).
//  mem_rvalid_i while inflight=0: ignored.
//  Empty FIFO: instr_valid_o=0; instr_o and instr_pc_o are don't-care.
//  Full FIFO: mem_req_o=0 until a pop.
//  Throughput: with ready held high and DEPTH>=3, one instruction per cycle sustained.
// TESTING
//  T1 reset, enable=1, ready=1, mem returns addr-tagged words:
//   first instr_valid_o at cycle 3, instr_pc_o 0x400000, 0x400004, ... one per cycle.
//  T2 ready=0 for 10 cycles:
//   count saturates at DEPTH=4, mem_req_o drops to 0, head stays 0x400000.
//   Raising ready drains in order with no loss or duplication.
//  T3 redirect_i with redirect_pc_i=0x400103 while 3 entries queued and 1 in flight:
//   next cycle count=0, no valid.
//   Next PCs delivered are 0x400100, 0x400104; the dropped response never appears.
//  T4 redirect in the same cycle as push and pop:
//   count=0 afterwards; first post-redirect instr_valid_o exactly 3 cycles later.
//  T5 pc=0xFFFF_FFFC, enable:
//   request addresses 0xFFFFFFFC then 0x00000000 (wrap).
//  T6 reset asserted for 1 cycle mid-stream with rvalid pending:
//   count=0, inflight=0; after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/instruction_fetch_queue.sv
// Instruction fetch queue: owns the fetch PC, issues word reads to a
// 1-cycle-latency program memory and buffers returned instructions (tagged
// with their PC) in a small FIFO drained over a valid/ready handshake.
// A redirect flushes queued and in-flight instructions and restarts fetch.
module instruction_fetch_queue #(
  parameter int                    DEPTH      = 4,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h0040_0000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable_i,
  input  logic                         redirect_i,
  input  logic [ADDR_WIDTH-1:0]        redirect_pc_i,
  output logic                         mem_req_o,
  output logic [ADDR_WIDTH-1:0]        mem_addr_o,
  input  logic                         mem_rvalid_i,
  input  logic [31:0]                  mem_rdata_i,
  output logic                         instr_valid_o,
  output logic [31:0]                  instr_o,
  output logic [ADDR_WIDTH-1:0]        instr_pc_o,
  input  logic                         instr_ready_i,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW:0]   DEPTH_OCC = (CW + 1)'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR  = PW'(DEPTH - 1);

  typedef enum logic {
    S_IDLE,
    S_FETCH
  } state_t;

  state_t                 state;
  logic [ADDR_WIDTH-1:0]  pc;
  logic [ADDR_WIDTH-1:0]  inflight_pc;
  logic                   inflight;

  logic [31:0]            data_mem [DEPTH];
  logic [ADDR_WIDTH-1:0]  pc_mem   [DEPTH];
  logic [PW-1:0]          head;
  logic [PW-1:0]          tail;
  logic [CW-1:0]          count;

  logic                   issue;
  logic                   push;
  logic                   pop;
  logic                   has_entry;
  logic [CW:0]            occupancy;
  logic [ADDR_WIDTH-1:0]  redirect_pc_aligned;

  // Circular pointer advance that works for non-power-of-two depths.
  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  // Occupancy counts the outstanding request so the FIFO can never overflow;
  // a pop in the same cycle deliberately gives no credit.
  assign occupancy           = {1'b0, count} + {{CW{1'b0}}, inflight};
  assign has_entry           = (count != '0);
  assign issue               = (state == S_FETCH) && enable_i && !redirect_i
                               && (occupancy < DEPTH_OCC);
  assign push                = inflight && mem_rvalid_i && !redirect_i;
  assign pop                 = has_entry && instr_ready_i;
  assign redirect_pc_aligned = redirect_pc_i & ~ADDR_WIDTH'(3);

  assign mem_req_o     = issue;
  assign mem_addr_o    = pc;
  assign instr_valid_o = has_entry;
  assign instr_o       = has_entry ? data_mem[head] : '0;
  assign instr_pc_o    = has_entry ? pc_mem[head]   : '0;
  assign count_o       = count;

  // Fetch FSM: fetching simply follows the enable input.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (enable_i)  state <= S_FETCH;
        S_FETCH: if (!enable_i) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Fetch PC and the single outstanding-request tracker (latency is fixed at 1).
  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= RESET_PC;
    end else if (redirect_i) begin
      pc       <= redirect_pc_aligned;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_pc <= pc;
        pc          <= pc + ADDR_WIDTH'(4);
      end
    end
  end

  // FIFO pointers and occupancy; redirect empties the queue like reset does.
  always_ff @(posedge clk) begin
    if (reset || redirect_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= ptr_next(tail);
      if (pop)  head <= ptr_next(head);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO storage: each returned word is written together with its request PC.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      data_mem[tail] <= mem_rdata_i;
      pc_mem[tail]   <= inflight_pc;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Self-checking bench for instruction_fetch_queue: directed table, hand-built
// corner-case sequences and a randomized run against a queue-based model.
module tb_instruction_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_ready_i;
  logic [2:0]  count_o;

  instruction_fetch_queue #(
    .DEPTH(DEPTH),
    .ADDR_WIDTH(32),
    .RESET_PC(RESET_PC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable_i(enable_i),
    .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .mem_req_o(mem_req_o),
    .mem_addr_o(mem_addr_o),
    .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i),
    .instr_valid_o(instr_valid_o),
    .instr_o(instr_o),
    .instr_pc_o(instr_pc_o),
    .instr_ready_i(instr_ready_i),
    .count_o(count_o)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [31:0] pc;
  } entry_t;

  typedef struct {
    bit          en;
    bit          rdy;
    bit          exp_req;
    logic [31:0] exp_addr;
    bit          exp_valid;
    logic [31:0] exp_pc;
    int          exp_count;
  } vec_t;

  entry_t      mq[$];
  logic [31:0] m_pc;
  logic [31:0] m_ifpc;
  bit          m_inflight;
  bit          m_fetch;
  bit          m_exp_req;

  bit          c_rst, c_en, c_redir, c_rv, c_rdy, c_req;
  logic [31:0] c_rpc, c_rd, c_addr;
  bit          inject_next = 1'b0;

  int total = 0;
  int bad   = 0;

  vec_t vecs[15];

  // Memory contents are a fixed scramble of the address.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input bit rst, input bit en, input bit rdy,
                               input bit redir, input logic [31:0] rpc);
    reset         = rst;
    enable_i      = en;
    instr_ready_i = rdy;
    redirect_i    = redir;
    redirect_pc_i = rpc;
    #1;
  endtask

  task automatic checkOutput();
    m_exp_req = m_fetch && enable_i && !redirect_i
                && ((mq.size() + int'(m_inflight)) < DEPTH);
    check("mem_req", {31'b0, mem_req_o}, {31'b0, m_exp_req});
    check("mem_addr", mem_addr_o, m_pc);
    check("instr_valid", {31'b0, instr_valid_o}, {31'b0, mq.size() != 0});
    check("count", {29'b0, count_o}, mq.size());
    if (mq.size() != 0) begin
      check("instr", instr_o, mq[0].data);
      check("instr_pc", instr_pc_o, mq[0].pc);
    end
  endtask

  task automatic modelUpdate();
    bit pop;
    bit push;
    if (c_rst) begin
      mq.delete();
      m_pc       = RESET_PC;
      m_inflight = 1'b0;
      m_fetch    = 1'b0;
    end else begin
      pop     = (mq.size() != 0) && c_rdy;
      push    = m_inflight && c_rv && !c_redir;
      m_fetch = c_en;
      if (c_redir) begin
        mq.delete();
        m_pc       = c_rpc & 32'hFFFF_FFFC;
        m_inflight = 1'b0;
      end else begin
        if (pop)  void'(mq.pop_front());
        if (push) mq.push_back('{c_rd, m_ifpc});
        if (m_exp_req) begin
          m_ifpc     = m_pc;
          m_pc       = m_pc + 32'd4;
          m_inflight = 1'b1;
        end else begin
          m_inflight = 1'b0;
        end
      end
    end
  endtask

  // One clock: compare against the model, advance it, then let memory answer.
  task automatic stepCycle();
    checkOutput();
    c_rst   = reset;
    c_en    = enable_i;
    c_redir = redirect_i;
    c_rpc   = redirect_pc_i;
    c_rv    = mem_rvalid_i;
    c_rd    = mem_rdata_i;
    c_rdy   = instr_ready_i;
    c_req   = mem_req_o;
    c_addr  = mem_addr_o;
    @(posedge clk);
    modelUpdate();
    @(negedge clk);
    mem_rvalid_i = c_req | inject_next;
    mem_rdata_i  = memWord(c_addr);
    inject_next  = 1'b0;
  endtask

  // Global time limit so the run always ends.
  initial begin
    #2_000_000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    // Table: after reset, enable and ready high, then ready low to fill, then drain.
    vecs[0]  = '{1, 1, 0, 32'h0040_0000, 0, 32'h0,          0};
    vecs[1]  = '{1, 1, 1, 32'h0040_0000, 0, 32'h0,          0};
    vecs[2]  = '{1, 1, 1, 32'h0040_0004, 0, 32'h0,          0};
    vecs[3]  = '{1, 1, 1, 32'h0040_0008, 1, 32'h0040_0000,  1};
    vecs[4]  = '{1, 1, 1, 32'h0040_000C, 1, 32'h0040_0004,  1};
    vecs[5]  = '{1, 1, 1, 32'h0040_0010, 1, 32'h0040_0008,  1};
    vecs[6]  = '{1, 0, 1, 32'h0040_0014, 1, 32'h0040_000C,  1};
    vecs[7]  = '{1, 0, 1, 32'h0040_0018, 1, 32'h0040_000C,  2};
    vecs[8]  = '{1, 0, 0, 32'h0040_001C, 1, 32'h0040_000C,  3};
    vecs[9]  = '{1, 0, 0, 32'h0040_001C, 1, 32'h0040_000C,  4};
    vecs[10] = '{1, 1, 0, 32'h0040_001C, 1, 32'h0040_000C,  4};
    vecs[11] = '{1, 1, 1, 32'h0040_001C, 1, 32'h0040_0010,  3};
    vecs[12] = '{1, 1, 1, 32'h0040_0020, 1, 32'h0040_0014,  2};
    vecs[13] = '{1, 1, 1, 32'h0040_0024, 1, 32'h0040_0018,  2};
    vecs[14] = '{1, 1, 1, 32'h0040_0028, 1, 32'h0040_001C,  2};

    reset         = 1'b1;
    enable_i      = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = '0;
    instr_ready_i = 1'b0;
    mem_rvalid_i  = 1'b0;
    mem_rdata_i   = '0;
    @(posedge clk);
    @(negedge clk);
    mq.delete();
    m_pc       = RESET_PC;
    m_ifpc     = RESET_PC;
    m_inflight = 1'b0;
    m_fetch    = 1'b0;

    // Reset state: everything zero except the address.
    applyStimulus(0, 0, 0, 0, 32'h0);
    check("rst_req", {31'b0, mem_req_o}, 32'd0);
    check("rst_addr", mem_addr_o, RESET_PC);
    check("rst_valid", {31'b0, instr_valid_o}, 32'd0);
    check("rst_instr", instr_o, 32'd0);
    check("rst_pc", instr_pc_o, 32'd0);
    check("rst_count", {29'b0, count_o}, 32'd0);
    stepCycle();

    for (int i = 0; i < 15; i++) begin
      applyStimulus(0, vecs[i].en, vecs[i].rdy, 0, 32'h0);
      check($sformatf("vec%0d_req", i), {31'b0, mem_req_o}, {31'b0, vecs[i].exp_req});
      check($sformatf("vec%0d_addr", i), mem_addr_o, vecs[i].exp_addr);
      check($sformatf("vec%0d_valid", i), {31'b0, instr_valid_o}, {31'b0, vecs[i].exp_valid});
      check($sformatf("vec%0d_count", i), {29'b0, count_o}, vecs[i].exp_count);
      if (vecs[i].exp_valid) begin
        check($sformatf("vec%0d_pc", i), instr_pc_o, vecs[i].exp_pc);
        check($sformatf("vec%0d_instr", i), instr_o, memWord(vecs[i].exp_pc));
      end
      stepCycle();
    end

    // Redirect with three queued entries and one in flight.
    applyStimulus(0, 1, 0, 0, 32'h0);
    stepCycle();
    applyStimulus(0, 1, 0, 1, 32'h0040_0103);
    check("t3_pre_count", {29'b0, count_o}, 32'd3);
    check("t3_redir_req", {31'b0, mem_req_o}, 32'd0);
    stepCycle();
    applyStimulus(0, 1, 1, 0, 32'h0);
    check("t3_count0", {29'b0, count_o}, 32'd0);
    check("t3_valid0", {31'b0, instr_valid_o}, 32'd0);
    check("t3_addr1", mem_addr_o, 32'h0040_0100);
    stepCycle();
    applyStimulus(0, 1, 1, 0, 32'h0);
    check("t3_valid_t2", {31'b0, instr_valid_o}, 32'd0);
    check("t3_addr2", mem_addr_o, 32'h0040_0104);
    stepCycle();
    applyStimulus(0, 1, 1, 0, 32'h0);
    check("t3_valid_t3", {31'b0, instr_valid_o}, 32'd1);
    check("t3_pc_a", instr_pc_o, 32'h0040_0100);
    stepCycle();
    applyStimulus(0, 1, 1, 0, 32'h0);
    check("t3_pc_b", instr_pc_o, 32'h0040_0104);
    stepCycle();

    // Redirect in the same cycle as a push and a pop.
    applyStimulus(0, 1, 1, 1, 32'h0040_0200);
    check("t4_pre_valid", {31'b0, instr_valid_o}, 32'd1);
    check("t4_pre_rvalid", {31'b0, mem_rvalid_i}, 32'd1);
    stepCycle();
    applyStimulus(0, 1, 1, 0, 32'h0);
    check("t4_count0", {29'b0, count_o}, 32'd0);
    stepCycle();
    applyStimulus(0, 1, 1, 0, 32'h0);
    check("t4_valid_t2", {31'b0, instr_valid_o}, 32'd0);
    stepCycle();
    applyStimulus(0, 1, 1, 0, 32'h0);
    check("t4_valid_t3", {31'b0, instr_valid_o}, 32'd1);
    check("t4_pc", instr_pc_o, 32'h0040_0200);
    stepCycle();

    // PC wrap at the top of the address space; low bits of the target ignored.
    applyStimulus(0, 1, 1, 1, 32'hFFFF_FFFE);
    stepCycle();
    applyStimulus(0, 1, 1, 0, 32'h0);
    check("t5_addr_top", mem_addr_o, 32'hFFFF_FFFC);
    check("t5_req_top", {31'b0, mem_req_o}, 32'd1);
    stepCycle();
    applyStimulus(0, 1, 1, 0, 32'h0);
    check("t5_addr_wrap", mem_addr_o, 32'h0000_0000);
    stepCycle();
    applyStimulus(0, 1, 1, 0, 32'h0);
    check("t5_pc_top", instr_pc_o, 32'hFFFF_FFFC);
    stepCycle();
    applyStimulus(0, 1, 1, 0, 32'h0);
    check("t5_pc_wrap", instr_pc_o, 32'h0000_0000);
    stepCycle();

    // One-cycle reset mid-stream with a response pending.
    applyStimulus(1, 1, 1, 0, 32'h0);
    stepCycle();
    applyStimulus(0, 1, 1, 0, 32'h0);
    check("t6_count0", {29'b0, count_o}, 32'd0);
    check("t6_req0", {31'b0, mem_req_o}, 32'd0);
    check("t6_addr", mem_addr_o, RESET_PC);
    stepCycle();
    applyStimulus(0, 1, 1, 0, 32'h0);
    check("t6_ignored", {29'b0, count_o}, 32'd0);
    check("t6_restart", mem_addr_o, RESET_PC);
    stepCycle();
    applyStimulus(0, 1, 1, 0, 32'h0);
    stepCycle();
    applyStimulus(0, 1, 1, 0, 32'h0);
    check("t6_first_pc", instr_pc_o, RESET_PC);
    stepCycle();

    // Drain with fetch disabled, redirect while idle, stray response ignored.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, 0, 1, 0, 32'h0);
      stepCycle();
    end
    applyStimulus(0, 0, 1, 1, 32'h0040_0300);
    inject_next = 1'b1;
    stepCycle();
    applyStimulus(0, 0, 1, 0, 32'h0);
    check("idle_addr", mem_addr_o, 32'h0040_0300);
    check("idle_req", {31'b0, mem_req_o}, 32'd0);
    stepCycle();
    applyStimulus(0, 1, 1, 0, 32'h0);
    check("stray_count", {29'b0, count_o}, 32'd0);
    stepCycle();
    applyStimulus(0, 1, 1, 0, 32'h0);
    check("idle_resume", mem_addr_o, 32'h0040_0300);
    check("idle_resume_req", {31'b0, mem_req_o}, 32'd1);
    stepCycle();

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] rpc;
      rpc = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
      inject_next = ($urandom_range(11) == 0);
      applyStimulus($urandom_range(299) == 0, $urandom_range(7) != 0,
                    $urandom_range(2) != 0, $urandom_range(29) == 0, rpc);
      stepCycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
